// File: rtl/mc_control_fsm_pkg.sv
// Shared MIPS control definitions: opcodes, datapath select encodings and the
// 4-bit state encodings that appear on state_o (HEX display logic decodes these).
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_FAULT   = 4'd15
  } state_t;

  // States that issue a memory request and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Opcode/memory-handshake inputs and datapath control outputs of the
// multi-cycle control unit; master = control FSM, slave = datapath.
interface mc_control_fsm_if;
  logic [5:0] opCode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] state_o;
  logic [1:0] fault;

  modport master (
    input  opCode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, RegWrite, RegDst, state_o, fault
  );

  modport slave (
    output opCode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, RegWrite, RegDst, state_o, fault
  );
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags a timeout
// when the count sits at WAIT_LIMIT with mem_ready still low (WAIT_LIMIT = 0 disables).
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Leaving a memory state zeroes the count, so every entry starts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_mem_state || mem_ready) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (WAIT_LIMIT != 0) && in_mem_state && !mem_ready && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM with mem_ready handshake, wait timeout and sticky fault.
// Define MCU_ADDI_EN to decode ADDI through the ADDIEX/ADDIWB states.
module mc_control_fsm
  import mips_defs::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus
);

  state_t     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic       timeout;

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CW         (CW)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .in_mem_state (is_mem_state(state_q)),
    .mem_ready    (bus.mem_ready),
    .timeout      (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    fault_d          = fault_q;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = SRCB_B;
    bus.ALUOp        = ALUOP_ADD;
    bus.PCSource     = PCSRC_ALU;
    bus.RegWrite     = 1'b0;
    bus.RegDst       = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        // IR and PC load only in the cycle the instruction word arrives.
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SL2;
        case (bus.opCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MCU_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`else
          OP_ADDI: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
`endif
          default: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = (bus.opCode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
        state_d     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALUOP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCSRC_JUMP;
        state_d      = S_FETCH;
      end
`ifdef MCU_ADDI_EN
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
`else
`endif
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Timeout only fires while a memory state is stalled, so it never
    // competes with a completed transfer.
    if (timeout) begin
      state_d = S_FAULT;
      fault_d = FAULT_TIMEOUT;
    end
  end

  assign bus.state_o = state_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed test of mc_control_fsm with WAIT_LIMIT = 3; ADDI checks follow MCU_ADDI_EN.
module tb_mc_control_fsm;
  import mips_defs::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mc_control_fsm_if bus_if();

  mc_control_fsm #(.WAIT_LIMIT(3), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus_if.mem_ready = 1'b0;
    bus_if.opCode = 6'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.mem_ready = 1'b0;
    bus_if.opCode = OP_LW;
    #2;
    total++; if (bus_if.state_o !== 4'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", bus_if.state_o); end
    total++; if (bus_if.MemRead !== 1'b1) begin bad++; $display("FAIL rst_memread: got %b want 1", bus_if.MemRead); end
    total++; if (bus_if.IRWrite !== 1'b0 || bus_if.PCWrite !== 1'b0) begin bad++; $display("FAIL rst_irw_pcw: got %b%b want 00", bus_if.IRWrite, bus_if.PCWrite); end
    total++; if (bus_if.ALUSrcB !== 2'b01 || bus_if.IorD !== 1'b0) begin bad++; $display("FAIL rst_srcb_iord: got %b/%b want 01/0", bus_if.ALUSrcB, bus_if.IorD); end
    total++; if (bus_if.fault !== 2'b00) begin bad++; $display("FAIL rst_fault: got %b want 00", bus_if.fault); end
    bus_if.mem_ready = 1'b1;
    #1;
    total++; if (bus_if.IRWrite !== 1'b1 || bus_if.PCWrite !== 1'b1) begin bad++; $display("FAIL fetch_mealy: got %b%b want 11", bus_if.IRWrite, bus_if.PCWrite); end
    $display("reset: state=%0d fault=%b", bus_if.state_o, bus_if.fault);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_lw;
    logic [3:0] exp_s [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    bus_if.opCode = OP_LW;
    bus_if.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus_if.state_o !== exp_s[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus_if.state_o, exp_s[i]); end
      total++; if (bus_if.RegWrite !== (exp_s[i] == 4'd4) || bus_if.MemtoReg !== (exp_s[i] == 4'd4)) begin
        bad++; $display("FAIL lw_wb[%0d]: got RegWrite=%b MemtoReg=%b", i, bus_if.RegWrite, bus_if.MemtoReg);
      end
    end
    $display("lw: final state=%0d", bus_if.state_o);
  endtask

  task automatic test_sw_wait;
    int writes = 0;
    do_reset();
    bus_if.opCode = OP_SW;
    bus_if.mem_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (bus_if.state_o !== 4'd5) begin bad++; $display("FAIL sw_enter: got %0d want 5", bus_if.state_o); end
    for (int k = 0; k < 4; k++) begin
      bus_if.mem_ready = (k == 3);
      #1;
      if (bus_if.MemWrite === 1'b1 && bus_if.state_o === 4'd5) writes++;
      tick();
    end
    total++; if (writes !== 4) begin bad++; $display("FAIL sw_write_cycles: got %0d want 4", writes); end
    total++; if (bus_if.state_o !== 4'd0 || bus_if.MemWrite !== 1'b0) begin bad++; $display("FAIL sw_done: got state %0d MemWrite %b want 0/0", bus_if.state_o, bus_if.MemWrite); end
    total++; if (bus_if.fault !== 2'b00) begin bad++; $display("FAIL sw_fault: got %b want 00", bus_if.fault); end
    $display("sw: write cycles=%0d state=%0d", writes, bus_if.state_o);
  endtask

  task automatic test_timeout;
    do_reset();
    bus_if.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus_if.state_o !== 4'd0) begin bad++; $display("FAIL to_wait[%0d]: got %0d want 0", k, bus_if.state_o); end
      tick();
    end
    total++; if (bus_if.state_o !== 4'd15 || bus_if.fault !== 2'b01) begin bad++; $display("FAIL to_fault: got %0d/%b want 15/01", bus_if.state_o, bus_if.fault); end
    bus_if.mem_ready = 1'b1;
    tick(); tick();
    total++; if (bus_if.state_o !== 4'd15 || bus_if.fault !== 2'b01) begin bad++; $display("FAIL to_sticky: got %0d/%b want 15/01", bus_if.state_o, bus_if.fault); end
    total++; if ({bus_if.MemRead, bus_if.IRWrite, bus_if.PCWrite, bus_if.ALUSrcB} !== 5'b0) begin
      bad++; $display("FAIL to_ctrl_zero: got MemRead=%b IRWrite=%b PCWrite=%b ALUSrcB=%b", bus_if.MemRead, bus_if.IRWrite, bus_if.PCWrite, bus_if.ALUSrcB);
    end
    do_reset();
    total++; if (bus_if.fault !== 2'b00 || bus_if.state_o !== 4'd0) begin bad++; $display("FAIL to_clear: got %0d/%b want 0/00", bus_if.state_o, bus_if.fault); end
    $display("timeout: fault cleared by reset, state=%0d", bus_if.state_o);
  endtask

  task automatic test_limit_boundary;
    do_reset();
    bus_if.opCode = OP_RTYPE;
    bus_if.mem_ready = 1'b0;
    tick(); tick(); tick();
    bus_if.mem_ready = 1'b1;
    #1;
    total++; if (bus_if.IRWrite !== 1'b1) begin bad++; $display("FAIL lim_irwrite: got %b want 1", bus_if.IRWrite); end
    tick();
    total++; if (bus_if.state_o !== 4'd1 || bus_if.fault !== 2'b00) begin bad++; $display("FAIL lim_complete: got %0d/%b want 1/00", bus_if.state_o, bus_if.fault); end
    $display("limit boundary: state=%0d fault=%b", bus_if.state_o, bus_if.fault);
  endtask

  task automatic test_illegal;
    do_reset();
    bus_if.opCode = 6'b111111;
    bus_if.mem_ready = 1'b1;
    tick(); tick();
    total++; if (bus_if.state_o !== 4'd15 || bus_if.fault !== 2'b10) begin bad++; $display("FAIL ill_fault: got %0d/%b want 15/10", bus_if.state_o, bus_if.fault); end
    tick();
    total++; if (bus_if.state_o !== 4'd15 || bus_if.RegWrite !== 1'b0 || bus_if.MemRead !== 1'b0) begin
      bad++; $display("FAIL ill_hold: got state %0d RegWrite %b MemRead %b", bus_if.state_o, bus_if.RegWrite, bus_if.MemRead);
    end
    $display("illegal: state=%0d fault=%b", bus_if.state_o, bus_if.fault);
  endtask

  task automatic test_addi;
    do_reset();
    bus_if.opCode = OP_ADDI;
    bus_if.mem_ready = 1'b1;
    tick(); tick();
`ifdef MCU_ADDI_EN
    total++; if (bus_if.state_o !== 4'd10 || bus_if.ALUSrcB !== 2'b10 || bus_if.ALUSrcA !== 1'b1) begin
      bad++; $display("FAIL addi_ex: got state %0d ALUSrcB %b ALUSrcA %b", bus_if.state_o, bus_if.ALUSrcB, bus_if.ALUSrcA);
    end
    tick();
    total++; if (bus_if.state_o !== 4'd11 || bus_if.RegWrite !== 1'b1 || bus_if.RegDst !== 1'b0) begin
      bad++; $display("FAIL addi_wb: got state %0d RegWrite %b RegDst %b", bus_if.state_o, bus_if.RegWrite, bus_if.RegDst);
    end
    tick();
    total++; if (bus_if.state_o !== 4'd0) begin bad++; $display("FAIL addi_done: got %0d want 0", bus_if.state_o); end
`else
    total++; if (bus_if.state_o !== 4'd15 || bus_if.fault !== 2'b10) begin bad++; $display("FAIL addi_illegal: got %0d/%b want 15/10", bus_if.state_o, bus_if.fault); end
`endif
    $display("addi: state=%0d fault=%b", bus_if.state_o, bus_if.fault);
  endtask

  task automatic test_beq;
    do_reset();
    bus_if.opCode = OP_BEQ;
    bus_if.mem_ready = 1'b1;
    tick();
    total++; if (bus_if.state_o !== 4'd1 || bus_if.ALUSrcB !== 2'b11) begin bad++; $display("FAIL beq_decode: got %0d/%b want 1/11", bus_if.state_o, bus_if.ALUSrcB); end
    tick();
    total++; if (bus_if.state_o !== 4'd8) begin bad++; $display("FAIL beq_state: got %0d want 8", bus_if.state_o); end
    total++; if (bus_if.PCWriteCond !== 1'b1 || bus_if.ALUOp !== 2'b01 || bus_if.PCSource !== 2'b01 || bus_if.PCWrite !== 1'b0) begin
      bad++; $display("FAIL beq_ctrl: got PCWriteCond %b ALUOp %b PCSource %b PCWrite %b", bus_if.PCWriteCond, bus_if.ALUOp, bus_if.PCSource, bus_if.PCWrite);
    end
    tick();
    total++; if (bus_if.state_o !== 4'd0) begin bad++; $display("FAIL beq_done: got %0d want 0", bus_if.state_o); end
    $display("beq: state=%0d", bus_if.state_o);
  endtask

  task automatic test_rtype_jump;
    do_reset();
    bus_if.opCode = OP_RTYPE;
    bus_if.mem_ready = 1'b1;
    tick(); tick();
    total++; if (bus_if.state_o !== 4'd6 || bus_if.ALUOp !== 2'b10 || bus_if.ALUSrcA !== 1'b1) begin
      bad++; $display("FAIL r_exec: got state %0d ALUOp %b ALUSrcA %b", bus_if.state_o, bus_if.ALUOp, bus_if.ALUSrcA);
    end
    tick();
    total++; if (bus_if.state_o !== 4'd7 || bus_if.RegDst !== 1'b1 || bus_if.RegWrite !== 1'b1) begin
      bad++; $display("FAIL r_wb: got state %0d RegDst %b RegWrite %b", bus_if.state_o, bus_if.RegDst, bus_if.RegWrite);
    end
    bus_if.opCode = OP_J;
    tick(); tick(); tick();
    total++; if (bus_if.state_o !== 4'd9 || bus_if.PCWrite !== 1'b1 || bus_if.PCSource !== 2'b10) begin
      bad++; $display("FAIL j_state: got state %0d PCWrite %b PCSource %b", bus_if.state_o, bus_if.PCWrite, bus_if.PCSource);
    end
    tick();
    total++; if (bus_if.state_o !== 4'd0) begin bad++; $display("FAIL j_done: got %0d want 0", bus_if.state_o); end
    $display("rtype+jump: state=%0d", bus_if.state_o);
  endtask

  task automatic test_reset_mid_memrd;
    do_reset();
    bus_if.opCode = OP_LW;
    bus_if.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus_if.mem_ready = 1'b0;
    tick();
    total++; if (bus_if.state_o !== 4'd3 || bus_if.IorD !== 1'b1) begin bad++; $display("FAIL mrd_wait: got %0d/%b want 3/1", bus_if.state_o, bus_if.IorD); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus_if.state_o !== 4'd0 || bus_if.MemRead !== 1'b1 || bus_if.IRWrite !== 1'b0) begin
      bad++; $display("FAIL mrd_async: got state %0d MemRead %b IRWrite %b", bus_if.state_o, bus_if.MemRead, bus_if.IRWrite);
    end
    total++; if (bus_if.fault !== 2'b00 || bus_if.RegWrite !== 1'b0 || bus_if.IorD !== 1'b0) begin
      bad++; $display("FAIL mrd_ctrl: got fault %b RegWrite %b IorD %b", bus_if.fault, bus_if.RegWrite, bus_if.IorD);
    end
    bus_if.mem_ready = 1'b1;
    tick();
    total++; if (bus_if.state_o !== 4'd0 || bus_if.RegWrite !== 1'b0) begin bad++; $display("FAIL mrd_held: got %0d/%b want 0/0", bus_if.state_o, bus_if.RegWrite); end
    reset = 1'b0;
    $display("reset mid-MEMRD: state=%0d", bus_if.state_o);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.mem_ready = 1'b0;
    bus_if.opCode = 6'd0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_timeout();
    test_limit_boundary();
    test_illegal();
    test_addi();
    test_beq();
    test_rtype_jump();
    test_reset_mid_memrd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
